// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised line, oversampled with s_tick, mid-bit sampling.
// Emits a one-clock done pulse per good frame and an error pulse when the stop bit reads low.
module uart_rx #(
    parameter int DBIT = 8,
    parameter int OS   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            rx_frame_err,
    output logic            rx_busy
);
    localparam int CW = $clog2(OS);
    localparam int NW = $clog2(DBIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(OS / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);
    localparam logic [NW-1:0] N_ONE    = NW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [NW-1:0]     n_r, n_s;
    logic [DBIT-1:0]   sreg_r, sreg_s;
    logic [DBIT-1:0]   dout_r, dout_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic              busy_r;
    logic              sync1_r, sync2_r;
    logic              rx_s;

    assign rx_s = sync2_r;

    // Next-state and datapath decode; counters only move on s_tick.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        n_s     = n_r;
        sreg_s  = sreg_r;
        dout_s  = dout_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_s = START;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (s_tick) begin
                    if (cnt_r == CNT_HALF) begin
                        if (!rx_s) begin
                            state_s = DATA;
                            cnt_s   = {CW{1'b0}};
                            n_s     = {NW{1'b0}};
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (cnt_r == CNT_LAST) begin
                        sreg_s = {rx_s, sreg_r[DBIT-1:1]};
                        cnt_s  = {CW{1'b0}};
                        if (n_r == N_LAST) begin
                            state_s = STOP;
                        end else begin
                            n_s = n_r + N_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (s_tick) begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (cnt_r == CNT_LAST) begin
                        dout_s  = sreg_r;
                        done_s  = rx_s;
                        err_s   = ~rx_s;
                        state_s = IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
                n_s     = {NW{1'b0}};
            end
        endcase
    end

    // Synchroniser, state and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            n_r     <= {NW{1'b0}};
            sreg_r  <= {DBIT{1'b0}};
            dout_r  <= {DBIT{1'b0}};
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            state_r <= state_s;
            cnt_r   <= cnt_s;
            n_r     <= n_s;
            sreg_r  <= sreg_s;
            dout_r  <= dout_s;
            done_r  <= done_s;
            err_r   <= err_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    assign rx_dout      = dout_r;
    assign rx_done_tick = done_r;
    assign rx_frame_err = err_r;
    assign rx_busy      = busy_r;
endmodule
